// File: rtl/rgb565_gray_stage.sv
// rgb565_gray_stage
// Converts RGB565 pixels to 8-bit luminance (77R + 150G + 29B) >> 8.
// The stage is a two-deep pipeline with a valid/ready handshake on each side.
// Output pixels carry end-of-line and end-of-frame markers, which come from
// raster counters that advance on every output handshake.
// Optional feature: define RGB565_GRAY_MINMAX_EN to add per-frame minimum and
// maximum luminance outputs (frame_min / frame_max).
module rgb565_gray_stage #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PX_W  = 15
) (
    input  logic            sobel_clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_px_rgb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PX_W-1:0] output_px_gray,
    output logic            out_eol,
    output logic            out_last,
    output logic            frame_done
`ifdef RGB565_GRAY_MINMAX_EN
    ,
    output logic [7:0]      frame_min,
    output logic [7:0]      frame_max
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Stage 1: expanded channel products; stage 2: luminance
    logic        s1_valid_reg;
    logic [15:0] prod_r_reg;
    logic [15:0] prod_g_reg;
    logic [15:0] prod_b_reg;
    logic        s2_valid_reg;
    logic [7:0]  gray_reg;

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic          frame_done_reg;

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] prod_r_next;
    logic [15:0] prod_g_next;
    logic [15:0] prod_b_next;
    logic [16:0] sum_next;
    logic [7:0]  gray_next;
    logic        advance;
    logic        out_hs;
    logic        col_max;
    logic        row_max;

    // Bit replication maps 5/6-bit channels onto the full 0..255 range, so
    // full white lands exactly on 255 without any saturation.
    assign r8 = {in_px_rgb[15:11], in_px_rgb[15:13]};
    assign g8 = {in_px_rgb[10:5],  in_px_rgb[10:9]};
    assign b8 = {in_px_rgb[4:0],   in_px_rgb[4:2]};

    assign prod_r_next = 16'(r8) * 16'd77;
    assign prod_g_next = 16'(g8) * 16'd150;
    assign prod_b_next = 16'(b8) * 16'd29;

    // Coefficients add up to 256, so the sum never exceeds 16 bits and the
    // luminance is the upper byte, truncated.
    assign sum_next  = 17'(prod_r_reg) + 17'(prod_g_reg) + 17'(prod_b_reg);
    assign gray_next = 8'(sum_next >> 8);

    // Both stages move together whenever the output slot is free or draining
    assign advance = !s2_valid_reg || out_ready;
    assign out_hs  = s2_valid_reg && out_ready;

    // Upstream is held off while reset is asserted so every output reads 0
    assign in_ready = advance && reset;

    assign col_max = (col_reg == CW'(IMG_W - 1));
    assign row_max = (row_reg == RW'(IMG_H - 1));

    assign out_valid      = s2_valid_reg;
    assign output_px_gray = {{(PX_W - 8){1'b0}}, gray_reg};
    assign out_eol        = s2_valid_reg && col_max;
    assign out_last       = s2_valid_reg && col_max && row_max;
    assign frame_done     = frame_done_reg;

    // Two-stage pixel pipeline; bubbles travel through like pixels
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            prod_r_reg   <= '0;
            prod_g_reg   <= '0;
            prod_b_reg   <= '0;
            s2_valid_reg <= 1'b0;
            gray_reg     <= '0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            prod_r_reg   <= prod_r_next;
            prod_g_reg   <= prod_g_next;
            prod_b_reg   <= prod_b_next;
            s2_valid_reg <= s1_valid_reg;
            gray_reg     <= gray_next;
        end
    end

    // Raster position of the pixel currently on the output, moved by handshakes
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (out_hs) begin
            if (col_max) begin
                col_reg <= '0;
                row_reg <= row_max ? '0 : row_reg + RW'(1);
            end else begin
                col_reg <= col_reg + CW'(1);
            end
        end
    end

    // One-cycle pulse following the handoff of the frame's last pixel
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= out_hs && col_max && row_max;
        end
    end

`ifdef RGB565_GRAY_MINMAX_EN
    logic [7:0] run_min_reg;
    logic [7:0] run_max_reg;
    logic [7:0] frame_min_reg;
    logic [7:0] frame_max_reg;
    logic       first_px;

    assign first_px  = (col_reg == '0) && (row_reg == '0);
    assign frame_min = frame_min_reg;
    assign frame_max = frame_max_reg;

    // Running extrema restart on the frame's first pixel; results are
    // published on the frame_done cycle and held until the next one
    always_ff @(posedge sobel_clk or negedge reset) begin
        if (!reset) begin
            run_min_reg   <= 8'hFF;
            run_max_reg   <= 8'h00;
            frame_min_reg <= 8'hFF;
            frame_max_reg <= 8'h00;
        end else begin
            if (out_hs) begin
                if (first_px) begin
                    run_min_reg <= gray_reg;
                    run_max_reg <= gray_reg;
                end else begin
                    if (gray_reg < run_min_reg) run_min_reg <= gray_reg;
                    if (gray_reg > run_max_reg) run_max_reg <= gray_reg;
                end
            end
            if (frame_done_reg) begin
                frame_min_reg <= run_min_reg;
                frame_max_reg <= run_max_reg;
            end
        end
    end
`endif

endmodule

// File: doc/rgb565_gray_stage.md
Name: rgb565_gray_stage

Overview:
- Pixel-path stage directly upstream of the Sobel controller.
- Accepts RGB565 pixels from the input buffer reader and converts each to 8-bit luminance.
- Presents the result, zero-extended, on the 15-bit gray bus the Sobel controller consumes.
- Tracks raster position so downstream logic gets end-of-line and end-of-frame markers.

Parameters:
- IMG_W, 320, pixels per line.
- IMG_H, 240, lines per frame.
- PX_W, 15, width of the output gray pixel bus.

Ports:
- sobel_clk  input  1  pixel clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_px_rgb holds a valid pixel.
- in_ready  output  1  stage accepts the pixel this cycle.
- in_px_rgb  input  16  RGB565 pixel: R [15:11], G [10:5], B [4:0].
- out_valid  output  1  output_px_gray valid.
- out_ready  input  1  downstream accepts the pixel this cycle.
- output_px_gray  output  PX_W  {(PX_W-8) zeros, gray[7:0]}.
- out_eol  output  1  qualifies output pixel as last of its line.
- out_last  output  1  qualifies output pixel as last of the frame.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is handed off.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; both pipe stages empty; column and row counters 0; frame_done 0.
- Reset release: outputs stay 0 until the first accepted pixel reaches stage 2.
- Handshake: a transfer occurs on a clock edge where valid and ready are both 1.
- Pipeline advance: advance = !out_valid | out_ready.
- in_ready = advance.
- Stage 1 and stage 2 shift together when advance=1; hold when advance=0.
- Bubbles are not compressed.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 pixel/clock.
- Output data, out_eol and out_last are held stable while out_valid=1 and out_ready=0.
- Stage 1 (expand): R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Stage 1 (products): 77*R8, 150*G8, 29*B8, each registered as 16 bits.
- Stage 2: sum is 17 bits; gray = sum[15:8], truncated with no rounding.
- Gray range: full white gives 255 exactly; no saturation logic is needed.
- Raster counters: col and row advance only on an output handshake.
  - col wraps IMG_W-1 to 0 and increments row.
  - row wraps IMG_H-1 to 0 at the frame end.
- out_eol = out_valid & (col==IMG_W-1).
- out_last = out_eol & (row==IMG_H-1).
- frame_done pulses 1 cycle after the handshake carrying out_last, for exactly 1 cycle, even if out_ready stays low afterwards.
- Simultaneous input and output handshakes in the same cycle are legal; no pixel is lost or duplicated.
- Reset mid-frame: pipe contents are discarded and counters return to 0. The next accepted pixel is treated as col 0, row 0.

Optional Feature:
- Macro: RGB565_GRAY_MINMAX_EN.
- When defined:
  - Adds outputs frame_min[7:0] and frame_max[7:0].
  - Running min/max are updated on each output handshake.
  - Both are reinitialised at the first pixel of a frame (col=0, row=0).
  - Values are latched into frame_min/frame_max on the frame_done cycle and hold until the next frame_done.
  - Reset values: frame_min=8'hFF, frame_max=8'h00.
- When undefined: ports and logic are absent. Behaviour and timing are otherwise identical.

Test Plan:
- Single pixels with out_ready=1:
  - 16'hFFFF -> 255, 2 cycles after accept.
  - 16'hF800 -> 76.
  - 16'h07E0 -> 149.
  - 16'h001F -> 28.
  - 16'h0000 -> 0.
  - output_px_gray upper 7 bits are always 0.
- Back-to-back 10 pixels, then out_ready=0 for 5 cycles mid-stream:
  - in_ready drops the same cycle.
  - Output holds its value.
  - All 10 pixels delivered in order, none duplicated.
- Full 320x240 frame of 16'hFFFF with random out_ready:
  - out_eol seen exactly 240 times.
  - out_last asserted only on handshake 76800.
  - frame_done pulses once, 1 cycle later.
- Reset asserted after 1000 pixels, released, 76800 pixels resent:
  - No output until 2 cycles after the first new accept.
  - out_last on the 76800th new pixel.
- Second frame directly after the first: counters wrap to 0,0; out_eol/out_last timing is identical to frame 1.
- With RGB565_GRAY_MINMAX_EN, frame of alternating 16'h001F / 16'hF800: frame_min=28 and frame_max=76 after frame_done.
